// File: rtl/incr_sched_pkg.sv
// ----------------------------------------------------------------------------
// incr_sched_pkg
//   Shared definitions for the chained-increment scheduler:
//     - sched_state_e : controller state (IDLE / RUN / DONE)
//     - *_DEF         : default parameter values for the scheduler
//     - wrap_next     : modulo-n successor, used for the round-robin pointer
// ----------------------------------------------------------------------------
package incr_sched_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int STEP_W_DEF = 3;
    localparam int N_REQ_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_e;

    // Successor of idx in the ring 0..n-1.
    function automatic int unsigned wrap_next(input int unsigned idx,
                                              input int unsigned n);
        if ((idx + 1) >= n) begin
            return 0;
        end
        return idx + 1;
    endfunction

endpackage

// File: rtl/incr_unit.sv
// ----------------------------------------------------------------------------
// incr_unit
//   Shared add-one datapath. Purely combinational, wraps modulo 2^WIDTH
//   (the carry out of the top bit is dropped).
//   Ports:
//     a       in  WIDTH  operand
//     add_one out WIDTH  a + 1 (mod 2^WIDTH)
// ----------------------------------------------------------------------------
module incr_unit
    import incr_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] add_one
);

    assign add_one = a + WIDTH'(1);

endmodule

// File: rtl/incr_chain_sched.sv
// ----------------------------------------------------------------------------
// incr_chain_sched
//   Serialises chained add-one requests from N_REQ clients through a single
//   incr_unit. A request carries an operand and a pass count; the operand is
//   advanced by one per cycle until the count is exhausted, then the result
//   is presented with the owner's index. Round-robin arbitration, one
//   operation in flight.
//   Ports:
//     clock      in   1              system clock
//     reset      in   1              asynchronous active-high reset
//     req_valid  in   N_REQ          per-requester request pending
//     req_data   in   N_REQ*WIDTH    operands, requester i at [i*WIDTH +: WIDTH]
//     req_steps  in   N_REQ*STEP_W   pass counts, requester i at [i*STEP_W +: STEP_W]
//     req_ready  out  N_REQ          one-hot grant (combinational, IDLE only)
//     resp_valid out  1              result available
//     resp_ready in   1              consumer accepts result
//     resp_data  out  WIDTH          result
//     resp_id    out  ID_W           owner of the result
//     busy       out  1              controller not in IDLE
// ----------------------------------------------------------------------------
module incr_chain_sched
    import incr_sched_pkg::*;
#(
    parameter  int N_REQ  = N_REQ_DEF,
    parameter  int WIDTH  = WIDTH_DEF,
    parameter  int STEP_W = STEP_W_DEF,
    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*WIDTH-1:0]    req_data,
    input  logic [N_REQ*STEP_W-1:0]   req_steps,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [WIDTH-1:0]          resp_data,
    output logic [ID_W-1:0]           resp_id,
    output logic                      busy
);

    sched_state_e      r_state;
    sched_state_e      w_state_nxt;

    logic [WIDTH-1:0]  r_acc;
    logic [STEP_W-1:0] r_remaining;
    logic [ID_W-1:0]   r_owner;
    logic [ID_W-1:0]   r_rr_ptr;

    logic              w_found;
    logic [ID_W-1:0]   w_gidx;
    logic [ID_W:0]     w_scan;
    logic [N_REQ-1:0]  w_grant;
    logic [WIDTH-1:0]  w_sel_data;
    logic [STEP_W-1:0] w_sel_steps;
    logic [WIDTH-1:0]  w_acc_inc;

    // ------------------------------------------------------------------------
    // Round-robin pick: first valid requester at or above r_rr_ptr, wrapping.
    // The scan index is one bit wider so the wrap can be done by a single
    // conditional subtract instead of a modulo. Grants are suppressed while
    // reset is asserted so req_ready reads zero during reset.
    // ------------------------------------------------------------------------
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_scan  = '0;
        if ((r_state == IDLE) && !reset) begin
            for (int k = 0; k < N_REQ; k++) begin
                w_scan = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
                if (w_scan >= (ID_W+1)'(N_REQ)) begin
                    w_scan = w_scan - (ID_W+1)'(N_REQ);
                end
                if (!w_found && req_valid[w_scan[ID_W-1:0]]) begin
                    w_found = 1'b1;
                    w_gidx  = w_scan[ID_W-1:0];
                end
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_found) begin
            w_grant[w_gidx] = 1'b1;
        end
    end

    assign w_sel_data  = req_data[w_gidx*WIDTH +: WIDTH];
    assign w_sel_steps = req_steps[w_gidx*STEP_W +: STEP_W];

    // The single shared incrementer always looks at the current accumulator.
    incr_unit #(
        .WIDTH (WIDTH)
    ) u_incr (
        .a       (r_acc),
        .add_one (w_acc_inc)
    );

    // ------------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                // A zero pass count skips RUN and returns the operand as-is.
                if (w_found) begin
                    w_state_nxt = (w_sel_steps == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (r_remaining == STEP_W'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                // Returning to IDLE here means no new grant can coincide with
                // the response handshake; arbitration resumes next cycle.
                if (resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Operation registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc       <= '0;
            r_remaining <= '0;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_acc       <= w_sel_data;
                        r_remaining <= w_sel_steps;
                        r_owner     <= w_gidx;
                    end
                end
                RUN: begin
                    r_acc       <= w_acc_inc;
                    r_remaining <= r_remaining - STEP_W'(1);
                end
                DONE: begin
                    // The winner drops to lowest priority for the next pick.
                    if (resp_ready) begin
                        r_rr_ptr <= ID_W'(wrap_next(32'(r_owner),
                                                    int'(unsigned'(N_REQ))));
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. Response fields are driven from registers and zeroed outside
    // DONE, so they hold steady under backpressure and read zero otherwise.
    // ------------------------------------------------------------------------
    assign req_ready  = w_grant;
    assign busy       = (r_state != IDLE);
    assign resp_valid = (r_state == DONE);
    assign resp_data  = resp_valid ? r_acc   : '0;
    assign resp_id    = resp_valid ? r_owner : '0;

endmodule
